mul_div_scheduler: RTL

//  Sequences the shared multiply/divide execution unit of the Tomasulo core. Selects one ready

---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/mul_div_scheduler_if.sv | 39 +++
 rtl/mul_div_rr_picker.sv | 28 ++
 rtl/mul_div_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo core function codes, latencies and FSM state type
package tomasulo_pkg;

    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    localparam int DEF_MUL_LAT = 6;
    localparam int DEF_DIV_LAT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_scheduler_if.sv
// rtl/mul_div_scheduler_if.sv - reservation-station and CDB bundle of the mul/div scheduler
interface mul_div_scheduler_if #(
    parameter int NUM_RS = 3,
    parameter int DATA_W = 8,
    parameter int RD_W   = 4,
    parameter int ROB_W  = 3,
    parameter int IDX_W  = $clog2(NUM_RS)
);

    logic [NUM_RS-1:0]        rs_busy;
    logic [NUM_RS-1:0]        rs_rdy;
    logic [NUM_RS*4-1:0]      rs_func;
    logic [NUM_RS*DATA_W-1:0] rs_v1;
    logic [NUM_RS*DATA_W-1:0] rs_v2;
    logic [NUM_RS*RD_W-1:0]   rs_rd;
    logic [NUM_RS*ROB_W-1:0]  rs_rob;
    logic                     cdb_gnt;

    logic                     cdb_req;
    logic [2*DATA_W-1:0]      cdb_data;
    logic [RD_W-1:0]          cdb_rd;
    logic [ROB_W-1:0]         cdb_rob;
    logic                     rs_free;
    logic [IDX_W-1:0]         rs_free_idx;
    logic                     unit_busy;

    // scheduler side
    modport master (
        input  rs_busy, rs_rdy, rs_func, rs_v1, rs_v2, rs_rd, rs_rob, cdb_gnt,
        output cdb_req, cdb_data, cdb_rd, cdb_rob, rs_free, rs_free_idx, unit_busy
    );

    // reservation-station array / CDB arbiter side
    modport slave (
        output rs_busy, rs_rdy, rs_func, rs_v1, rs_v2, rs_rd, rs_rob, cdb_gnt,
        input  cdb_req, cdb_data, cdb_rd, cdb_rob, rs_free, rs_free_idx, unit_busy
    );

endinterface

// File: rtl/mul_div_rr_picker.sv
// rtl/mul_div_rr_picker.sv - combinational round-robin selector over N request lines
module mul_div_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // scan from ptr upward with wrap; the first requester found wins
    always_comb begin
        any_valid = 1'b0;
        idx       = '0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mul_div_scheduler.sv
// rtl/mul_div_scheduler.sv - issues one mul/div RS entry, models fixed latency, drives the CDB
module mul_div_scheduler
    import tomasulo_pkg::*;
#(
    parameter int NUM_RS  = 3,
    parameter int DATA_W  = 8,
    parameter int RD_W    = 4,
    parameter int ROB_W   = 3,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                flush,
    mul_div_scheduler_if.master bus
);

    localparam int IDX_W   = $clog2(NUM_RS);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e state;
    md_state_e state_nxt;

    logic [3:0]        func_a [NUM_RS];
    logic [DATA_W-1:0] v1_a   [NUM_RS];
    logic [DATA_W-1:0] v2_a   [NUM_RS];
    logic [RD_W-1:0]   rd_a   [NUM_RS];
    logic [ROB_W-1:0]  rob_a  [NUM_RS];
    logic [NUM_RS-1:0] eligible;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic              issue;

    logic [3:0]        func_q;
    logic [DATA_W-1:0] v1_q;
    logic [DATA_W-1:0] v2_q;
    logic [RD_W-1:0]   rd_q;
    logic [ROB_W-1:0]  rob_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt;

    logic [2*DATA_W-1:0] cdb_data_q;
    logic [RD_W-1:0]     cdb_rd_q;
    logic [ROB_W-1:0]    cdb_rob_q;
    logic                free_q;
    logic [IDX_W-1:0]    free_idx_q;
    logic                retire;
    logic                finish;

    function automatic logic [2*DATA_W-1:0] md_result(
        input logic [3:0]        f,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if (f == FUNC_MUL)
            return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        else if (b == '0)
            return '1;
        else
            return {{DATA_W{1'b0}}, a / b};
    endfunction

    // unpack the flattened RS buses and decide which entries may issue; the entry being
    // released this cycle is still marked busy by the RS array, so it is masked out here
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            func_a[i]   = bus.rs_func[i*4 +: 4];
            v1_a[i]     = bus.rs_v1[i*DATA_W +: DATA_W];
            v2_a[i]     = bus.rs_v2[i*DATA_W +: DATA_W];
            rd_a[i]     = bus.rs_rd[i*RD_W +: RD_W];
            rob_a[i]    = bus.rs_rob[i*ROB_W +: ROB_W];
            eligible[i] = bus.rs_busy[i] & bus.rs_rdy[i]
                        & ((func_a[i] == FUNC_MUL) | (func_a[i] == FUNC_DIV))
                        & ~(free_q & (free_idx_q == IDX_W'(i)));
        end
    end

    mul_div_rr_picker #(
        .N     (NUM_RS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (eligible),
        .ptr       (rr_ptr),
        .any_valid (pick_valid),
        .idx       (pick_idx)
    );

    assign issue  = (state == IDLE) & pick_valid & ~flush;
    assign finish = (state == EXEC) & (cnt == '0) & ~flush;
    assign retire = (state == WB) & bus.cdb_gnt & ~flush;

    // FSM state register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; flush returns to IDLE from anywhere and beats cdb_gnt
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = EXEC;
            EXEC:    if (flush) state_nxt = IDLE;
                     else if (cnt == '0) state_nxt = WB;
            WB:      if (flush || bus.cdb_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        bus.cdb_req   = (state == WB);
        bus.unit_busy = (state != IDLE);
    end

    // issue: latch the selected entry, load the latency counter, advance the RR pointer
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            rd_q   <= '0;
            rob_q  <= '0;
            idx_q  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else if (issue) begin
            func_q <= func_a[pick_idx];
            v1_q   <= v1_a[pick_idx];
            v2_q   <= v2_a[pick_idx];
            rd_q   <= rd_a[pick_idx];
            rob_q  <= rob_a[pick_idx];
            idx_q  <= pick_idx;
            cnt    <= (func_a[pick_idx] == FUNC_MUL) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
            rr_ptr <= (pick_idx == IDX_W'(NUM_RS - 1)) ? '0 : pick_idx + 1'b1;
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // result and tags land on the CDB registers together on the last EXEC cycle
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cdb_data_q <= '0;
            cdb_rd_q   <= '0;
            cdb_rob_q  <= '0;
        end else if (finish) begin
            cdb_data_q <= md_result(func_q, v1_q, v2_q);
            cdb_rd_q   <= rd_q;
            cdb_rob_q  <= rob_q;
        end
    end

    // one-cycle release pulse following the granted WB cycle
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            free_q     <= 1'b0;
            free_idx_q <= '0;
        end else begin
            free_q <= retire;
            if (retire) free_idx_q <= idx_q;
        end
    end

    assign bus.cdb_data    = cdb_data_q;
    assign bus.cdb_rd      = cdb_rd_q;
    assign bus.cdb_rob     = cdb_rob_q;
    assign bus.rs_free     = free_q;
    assign bus.rs_free_idx = free_idx_q;

endmodule
